// File: rtl/cb_ram_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM bank between the system-bus
// masters (OBI-style req/gnt/rvalid). Accesses that fall outside the bank window
// are granted, answered with 32'hBADACCE5, and counted in a saturating counter.
module cb_ram_bank_arbiter #(
  parameter int          NMASTER    = 5,
  parameter logic [31:0] BANK_START = 32'hF0100000,
  parameter logic [31:0] BANK_SIZE  = 32'h00008000,
  parameter int          MEM_AW     = $clog2(BANK_SIZE / 4)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NMASTER-1:0]      master_req_i,
  input  logic [NMASTER-1:0]      master_we_i,
  input  logic [4*NMASTER-1:0]    master_be_i,
  input  logic [32*NMASTER-1:0]   master_addr_i,
  input  logic [32*NMASTER-1:0]   master_wdata_i,
  output logic [NMASTER-1:0]      master_gnt_o,
  output logic [NMASTER-1:0]      master_rvalid_o,
  output logic [32*NMASTER-1:0]   master_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  output logic [15:0]             err_count_o
);

  localparam int          PW       = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic          grant;

  logic          win_we;
  logic [3:0]    win_be;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic [31:0]   offset;
  logic          in_window;
  logic          mem_go;

  logic          resp_valid_q;
  logic          resp_err_q;
  logic [PW-1:0] resp_idx_q;
  logic [15:0]   err_count;
  logic [31:0]   resp_data;

  // Pick the first requester at or after rr_ptr, wrapping modulo NMASTER.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NMASTER; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NMASTER);
      if (!found && master_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Nothing is granted while reset is held, so every output reads 0 in reset.
  assign grant = found & rst_ni;

  assign win_we    = master_we_i[winner];
  assign win_be    = master_be_i[int'(winner) * 4 +: 4];
  assign win_addr  = master_addr_i[int'(winner) * 32 +: 32];
  assign win_wdata = master_wdata_i[int'(winner) * 32 +: 32];

  // Window check: the subtraction wraps for addresses below the window, so both
  // ends are tested explicitly.
  assign offset    = win_addr - BANK_START;
  assign in_window = (win_addr >= BANK_START) && (offset < BANK_SIZE);
  assign mem_go    = grant & in_window;

  assign master_gnt_o = grant ? (NMASTER'(1) << winner) : '0;

  // Drive the SRAM from the winner; all memory outputs idle at 0 otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_go) begin
      mem_req_o   = 1'b1;
      mem_we_o    = win_we;
      mem_be_o    = win_be;
      mem_addr_o  = offset[MEM_AW+1:2];
      mem_wdata_o = win_wdata;
    end
  end

  // Advance the round-robin pointer past the master just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (winner == PW'(NMASTER - 1)) ? '0 : winner + PW'(1);
    end
  end

  // Capture who was granted and whether it missed the window; reply next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_err_q   <= 1'b0;
    end else if (grant) begin
      resp_valid_q <= 1'b1;
      resp_idx_q   <= winner;
      resp_err_q   <= ~in_window;
    end else begin
      resp_valid_q <= 1'b0;
    end
  end

  // Count out-of-window accesses, sticking at the maximum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count <= '0;
    end else if (grant && !in_window && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign resp_data       = !resp_valid_q ? '0 : (resp_err_q ? ERR_DATA : mem_rdata_i);
  assign master_rvalid_o = resp_valid_q ? (NMASTER'(1) << resp_idx_q) : '0;
  assign master_rdata_o  = {NMASTER{resp_data}};
  assign err_count_o     = err_count;

endmodule

// File: doc/cb_ram_bank_arbiter.md
Name: cb_ram_bank_arbiter

Overview:
- Round-robin arbiter that shares one single-ported SRAM bank (MEMORY_RAM0 or MEMORY_RAM1 window) between the system-bus masters: CORE0 instr/data, CORE1 instr/data and the external master.
- Sits between the system crossbar slave port and the SRAM macro. Masters use the OBI-style req/gnt/rvalid protocol.
- Returns a 32'hBADACCE5 error response for addresses outside the bank window.
- Counts error accesses in a saturating counter.

Parameters:
- NMASTER, 5, number of requesting masters (index order: CORE0_INSTR=0, CORE0_DATA=1, CORE1_INSTR=2, CORE1_DATA=3, EXTERNAL=4)
- BANK_START, 32'hF0100000, first byte address of the bank window
- BANK_SIZE, 32'h00008000, bank window size in bytes; power of two, at least 8
- MEM_AW, $clog2(BANK_SIZE/4), width of the SRAM word address (13 at default)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- master_req_i  in  NMASTER  per-master request
- master_we_i  in  NMASTER  per-master write enable
- master_be_i  in  4*NMASTER  byte enables; master k uses bits [4k+3:4k]
- master_addr_i  in  32*NMASTER  byte addresses
- master_wdata_i  in  32*NMASTER  write data
- master_gnt_o  out  NMASTER  grant; one-hot or zero
- master_rvalid_o  out  NMASTER  response valid; one-hot or zero
- master_rdata_o  out  32*NMASTER  read data; response data is broadcast on all slices
- mem_req_o  out  1  SRAM chip enable
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o
- err_count_o  out  16  saturating count of out-of-window accesses

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, resp_valid_q=0, resp_idx_q=0, resp_err_q=0, err_count=0. While in reset all outputs are 0.
- Arbitration (combinational, every cycle):
  - Winner = first k with master_req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod NMASTER.
  - master_gnt_o[winner]=1 in the same cycle; no grant when no request.
- rr_ptr update: on any grant, rr_ptr <= (winner+1) mod NMASTER; otherwise it holds.
- Throughput and latency:
  - One grant per cycle; back-to-back grants are allowed.
  - No backpressure on responses.
  - Response latency is exactly 1 cycle after grant.
- In-window request (BANK_START <= addr < BANK_START+BANK_SIZE):
  - mem_req_o=1; mem_we_o, mem_be_o, mem_wdata_o taken from the winner.
  - mem_addr_o = (addr-BANK_START)[MEM_AW+1:2]; addr[1:0] is ignored.
- Out-of-window request:
  - Still granted; mem_req_o=0.
  - err_count increments by 1 and saturates at 16'hFFFF.
- Idle memory outputs: when mem_req_o=0, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are driven 0.
- Response registers: on a grant, resp_valid_q<=1, resp_idx_q<=winner, resp_err_q<=out-of-window; else resp_valid_q<=0.
- Response output:
  - master_rvalid_o[resp_idx_q] = resp_valid_q.
  - master_rdata_o (every slice) = resp_err_q ? 32'hBADACCE5 : mem_rdata_i, gated to 0 when resp_valid_q=0.
- Writes also receive rvalid. rdata for a write response is don't-care; the bench checks rvalid only.
- Request persistence: a master keeps req and its payload stable until gnt. A master may drop req without a grant; no state is kept for it.
- Same-master back-to-back: re-granting the same master is allowed only when it is the sole requester.
- Fairness: with all NMASTER requesting continuously, each master is granted exactly once every NMASTER cycles.
- Reset mid-transaction: a pending response is discarded, with no rvalid after reset release; the SRAM transaction in flight is abandoned.

Test Plan:
- Single master 1 writes 32'hCAFEF00D to 0xF0100010 with be=4'hF, then reads it → gnt same cycle both times; mem_addr_o=13'd4; rvalid[1] one cycle after each grant; read rdata=32'hCAFEF00D.
- All 5 masters request reads continuously for 10 cycles from reset → grant order 0,1,2,3,4,0,1,2,3,4; each rvalid follows its grant by 1 cycle to the matching index.
- Master 3 reads 0xF0108000 (one past the window) → gnt[3]=1, mem_req_o=0, next cycle rvalid[3]=1 with rdata=32'hBADACCE5; err_count_o=1.
- 65540 out-of-window accesses → err_count_o saturates at 16'hFFFF.
- Masters 2 and 4 request with rr_ptr=3 → master 4 granted first, then master 2; rr_ptr ends at 3.
- Assert rst_ni in the cycle after a grant → no rvalid after release; all outputs 0 during reset; rr_ptr=0 after release.
